// File: rtl/decode_pkg.sv
// Shared encodings and the fixed-width control part of the decoded bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package decode_pkg;

    localparam int INSTR_W   = 32;
    localparam int LINK_REG  = 14;
    localparam int PC_OFFSET = 8;

    typedef enum logic [1:0] {
        CLS_ALU   = 2'b00,
        CLS_MEM   = 2'b01,
        CLS_BR    = 2'b10,
        CLS_UNDEF = 2'b11
    } cls_e;

    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_CMN = 4'b1011;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Register indices and wide datapath fields are parameter-sized, so they
    // travel beside this struct rather than inside it.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       rn_used;
        logic       rm_used;
        logic       reg_we;
        logic       imm_en;
        logic [1:0] shift_type;
        logic [4:0] shift_amt;
        logic       mem_load;
        logic       mem_store;
        logic       jump_en;
        logic [3:0] cond;
        logic       undef;
    } dec_ctl_t;

    function automatic logic is_compare_op(input logic [3:0] op);
        return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready valid-ready pairs plus flush.
interface decode_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_instr;
    logic [DATA_W-1:0]     in_pc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_alu_op;
    logic [REG_ADDR_W-1:0] out_rd;
    logic [REG_ADDR_W-1:0] out_rn;
    logic [REG_ADDR_W-1:0] out_rm;
    logic                  out_rn_used;
    logic                  out_rm_used;
    logic                  out_reg_we;
    logic                  out_imm_en;
    logic [DATA_W-1:0]     out_imm;
    logic [1:0]            out_shift_type;
    logic [4:0]            out_shift_amt;
    logic                  out_mem_load;
    logic                  out_mem_store;
    logic                  out_jump_en;
    logic [DATA_W-1:0]     out_jump_target;
    logic [3:0]            out_cond;
    logic                  out_undef;
    logic [DATA_W-1:0]     out_pc;
    logic [CNT_W-1:0]      stall_count;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out_alu_op, out_rd, out_rn, out_rm,
               out_rn_used, out_rm_used, out_reg_we, out_imm_en, out_imm,
               out_shift_type, out_shift_amt, out_mem_load, out_mem_store,
               out_jump_en, out_jump_target, out_cond, out_undef, out_pc,
               stall_count
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_alu_op, out_rd, out_rn, out_rm,
               out_rn_used, out_rm_used, out_reg_we, out_imm_en, out_imm,
               out_shift_type, out_shift_amt, out_mem_load, out_mem_store,
               out_jump_en, out_jump_target, out_cond, out_undef, out_pc,
               stall_count
    );
endinterface

// File: rtl/imm_rotator.sv
// ARM rotated immediate: zero-extended imm8 rotated right by 2*rot.
// Latency: combinational.
// Backpressure: none.
module imm_rotator (
    input  logic [7:0]  imm8,
    input  logic [3:0]  rot,
    output logic [31:0] result
);
    logic [63:0] doubled;

    // Shifting a doubled copy right gives the rotation in its low half.
    assign doubled = {24'd0, imm8, 24'd0, imm8} >> {rot, 1'b0};
    assign result  = doubled[31:0];
endmodule

// File: rtl/decode_stage.sv
// Registered instruction decode between fetch and execute; DECODE_BL_EN adds BL link writeback.
// Latency: one cycle from transfer-in to out_valid, full throughput without hazards.
// Backpressure: holds bundle until out_ready; one bubble per load-use hazard; flush drops held and incoming.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    decode_stage_if.slave io
);

    logic [31:0]           instr;
    logic [31:0]           rot_imm;
    dec_ctl_t              ctl_dec, ctl_d, ctl_q;
    logic [REG_ADDR_W-1:0] rd_dec, rn_dec, rm_dec;
    logic [REG_ADDR_W-1:0] rd_d, rd_q, rn_d, rn_q, rm_d, rm_q;
    logic [DATA_W-1:0]     imm_dec, tgt_dec;
    logic [DATA_W-1:0]     imm_d, imm_q, tgt_d, tgt_q, pc_d, pc_q;
    logic                  vld_d, vld_q;
    logic [CNT_W-1:0]      stall_cnt_d, stall_cnt_q;
    logic                  hazard, xfer_in;

    assign instr = io.in_instr;

    imm_rotator u_imm_rotator (
        .imm8   (instr[7:0]),
        .rot    (instr[11:8]),
        .result (rot_imm)
    );

    always_comb begin
        ctl_dec      = '0;
        rd_dec       = '0;
        rn_dec       = '0;
        rm_dec       = '0;
        imm_dec      = '0;
        tgt_dec      = '0;
        ctl_dec.cond = instr[31:28];
        case (cls_e'(instr[27:26]))
            CLS_ALU: begin
                ctl_dec.alu_op  = instr[24:21];
                ctl_dec.rn_used = 1'b1;
                ctl_dec.reg_we  = 1'b1;
                rn_dec          = REG_ADDR_W'(instr[19:16]);
                rd_dec          = REG_ADDR_W'(instr[15:12]);
                if (instr[25]) begin
                    ctl_dec.imm_en = 1'b1;
                    imm_dec        = DATA_W'(rot_imm);
                end else begin
                    ctl_dec.rm_used    = 1'b1;
                    ctl_dec.shift_type = instr[6:5];
                    ctl_dec.shift_amt  = instr[11:7];
                    rm_dec             = REG_ADDR_W'(instr[3:0]);
                end
                if (is_compare_op(instr[24:21])) begin
                    ctl_dec.reg_we = 1'b0;
                    rd_dec         = '0;
                end
                if (instr[24:21] == OP_MOV || instr[24:21] == OP_MVN) begin
                    ctl_dec.rn_used = 1'b0;
                    rn_dec          = '0;
                end
            end
            CLS_MEM: begin
                ctl_dec.rn_used = 1'b1;
                ctl_dec.imm_en  = 1'b1;
                rn_dec          = REG_ADDR_W'(instr[19:16]);
                imm_dec         = DATA_W'(instr[11:0]);
                if (instr[20]) begin
                    ctl_dec.mem_load = 1'b1;
                    ctl_dec.reg_we   = 1'b1;
                    rd_dec           = REG_ADDR_W'(instr[15:12]);
                end else begin
                    ctl_dec.mem_store = 1'b1;
                    ctl_dec.rm_used   = 1'b1;
                    rm_dec            = REG_ADDR_W'(instr[15:12]);
                end
            end
            CLS_BR: begin
                ctl_dec.jump_en = 1'b1;
                tgt_dec = io.in_pc + DATA_W'(PC_OFFSET)
                        + (DATA_W'($signed(instr[23:0])) << 2);
`ifdef DECODE_BL_EN
                if (instr[24]) begin
                    ctl_dec.reg_we = 1'b1;
                    rd_dec         = REG_ADDR_W'(LINK_REG);
                end
`endif
            end
            default: begin
                ctl_dec.undef = 1'b1;
            end
        endcase
    end

    // Only a bundle execute is about to consume can forward a stale load result.
    assign hazard = vld_q && ctl_q.mem_load && io.out_ready && io.in_valid &&
                    ((ctl_dec.rn_used && rn_dec == rd_q) ||
                     (ctl_dec.rm_used && rm_dec == rd_q));

    assign io.in_ready = io.flush || ((!vld_q || io.out_ready) && !hazard);
    assign xfer_in     = io.in_valid && io.in_ready && !io.flush;

    always_comb begin
        vld_d       = vld_q;
        ctl_d       = ctl_q;
        rd_d        = rd_q;
        rn_d        = rn_q;
        rm_d        = rm_q;
        imm_d       = imm_q;
        tgt_d       = tgt_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;
        if (io.flush) begin
            vld_d = 1'b0;
        end else if (hazard) begin
            vld_d = 1'b0;
            ctl_d = '0;
            rd_d  = '0;
            rn_d  = '0;
            rm_d  = '0;
            imm_d = '0;
            tgt_d = '0;
            pc_d  = '0;
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (xfer_in) begin
            vld_d = 1'b1;
            ctl_d = ctl_dec;
            rd_d  = rd_dec;
            rn_d  = rn_dec;
            rm_d  = rm_dec;
            imm_d = imm_dec;
            tgt_d = tgt_dec;
            pc_d  = io.in_pc;
        end else if (io.out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q       <= 1'b0;
            ctl_q       <= '0;
            rd_q        <= '0;
            rn_q        <= '0;
            rm_q        <= '0;
            imm_q       <= '0;
            tgt_q       <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            ctl_q       <= ctl_d;
            rd_q        <= rd_d;
            rn_q        <= rn_d;
            rm_q        <= rm_d;
            imm_q       <= imm_d;
            tgt_q       <= tgt_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign io.out_valid       = vld_q;
    assign io.out_alu_op      = ctl_q.alu_op;
    assign io.out_rd          = rd_q;
    assign io.out_rn          = rn_q;
    assign io.out_rm          = rm_q;
    assign io.out_rn_used     = ctl_q.rn_used;
    assign io.out_rm_used     = ctl_q.rm_used;
    assign io.out_reg_we      = ctl_q.reg_we;
    assign io.out_imm_en      = ctl_q.imm_en;
    assign io.out_imm         = imm_q;
    assign io.out_shift_type  = ctl_q.shift_type;
    assign io.out_shift_amt   = ctl_q.shift_amt;
    assign io.out_mem_load    = ctl_q.mem_load;
    assign io.out_mem_store   = ctl_q.mem_store;
    assign io.out_jump_en     = ctl_q.jump_en;
    assign io.out_jump_target = tgt_q;
    assign io.out_cond        = ctl_q.cond;
    assign io.out_undef       = ctl_q.undef;
    assign io.out_pc          = pc_q;
    assign io.stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases then random traffic against a reference model.
module tb_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(16)) io ();

    decode_stage #(.DATA_W(32), .REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [3:0]  rd, rn, rm;
        logic        rn_used, rm_used, reg_we, imm_en, ld, st, jmp, undef;
        logic [31:0] imm;
        logic [1:0]  sh_t;
        logic [4:0]  sh_a;
        logic [31:0] tgt;
        logic [3:0]  cond;
        logic [31:0] pc;
    } ref_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic m_vld = 1'b0;
    ref_t m_b = '0;
    int   m_stalls = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Decode straight from the instruction-set rules.
    function automatic ref_t dec_ref(input logic [31:0] i, input logic [31:0] pc);
        ref_t r;
        logic [31:0] x;
        int off;
        r = '0;
        r.cond = i[31:28];
        r.pc = pc;
        if (i[27:26] == 2'b00) begin
            r.alu_op = i[24:21];
            r.rn = i[19:16]; r.rd = i[15:12];
            r.rn_used = 1; r.reg_we = 1;
            if (i[25]) begin
                r.imm_en = 1;
                x = {24'd0, i[7:0]};
                for (int k = 0; k < 2 * int'(i[11:8]); k++) x = {x[0], x[31:1]};
                r.imm = x;
            end else begin
                r.rm = i[3:0]; r.rm_used = 1; r.sh_t = i[6:5]; r.sh_a = i[11:7];
            end
            if (r.alu_op >= 8 && r.alu_op <= 11) begin r.reg_we = 0; r.rd = 0; end
            if (r.alu_op == 13 || r.alu_op == 15) begin r.rn_used = 0; r.rn = 0; end
        end else if (i[27:26] == 2'b01) begin
            r.rn = i[19:16]; r.rn_used = 1; r.imm = {20'd0, i[11:0]}; r.imm_en = 1;
            if (i[20]) begin r.ld = 1; r.reg_we = 1; r.rd = i[15:12]; end
            else begin r.st = 1; r.rm = i[15:12]; r.rm_used = 1; end
        end else if (i[27:26] == 2'b10) begin
            r.jmp = 1;
            off = i[23] ? int'(i[23:0]) - (1 << 24) : int'(i[23:0]);
            r.tgt = pc + 32'd8 + 32'(off * 4);
`ifdef DECODE_BL_EN
            if (i[24]) begin r.reg_we = 1; r.rd = 4'd14; end
`endif
        end else begin
            r.undef = 1;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
        io.in_valid  = v;
        io.in_instr  = ins;
        io.in_pc     = pc;
        io.out_ready = ordy;
        io.flush     = fl;
    endtask

    // Check at negedge, advance the model at posedge, return #1 after the edge.
    task automatic step();
        ref_t d;
        logic hz, er;
        @(negedge clk);
        d  = dec_ref(io.in_instr, io.in_pc);
        hz = m_vld && m_b.ld && io.out_ready && io.in_valid &&
             ((d.rn_used && d.rn == m_b.rd) || (d.rm_used && d.rm == m_b.rd));
        er = io.flush || ((!m_vld || io.out_ready) && !hz);
        chk("in_ready", io.in_ready, er);
        chk("out_valid", io.out_valid, m_vld);
        chk("stall_count", io.stall_count, m_stalls);
        if (m_vld) begin
            chk("regs", {io.out_rd, io.out_rn, io.out_rm}, {m_b.rd, m_b.rn, m_b.rm});
            chk("flags", {io.out_rn_used, io.out_rm_used, io.out_reg_we, io.out_imm_en,
                          io.out_mem_load, io.out_mem_store, io.out_jump_en, io.out_undef},
                         {m_b.rn_used, m_b.rm_used, m_b.reg_we, m_b.imm_en,
                          m_b.ld, m_b.st, m_b.jmp, m_b.undef});
            chk("op_fields", {io.out_alu_op, io.out_shift_type, io.out_shift_amt, io.out_cond},
                             {m_b.alu_op, m_b.sh_t, m_b.sh_a, m_b.cond});
            chk("imm", io.out_imm, m_b.imm);
            chk("target", io.out_jump_target, m_b.tgt);
            chk("pc", io.out_pc, m_b.pc);
        end
        @(posedge clk);
        if (io.flush) m_vld = 0;
        else if (hz) begin
            m_vld = 0;
            if (m_stalls < 65535) m_stalls++;
        end else if (io.in_valid && er) begin
            m_vld = 1;
            m_b = d;
        end else if (io.out_ready) m_vld = 0;
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int c;
        w = $urandom;
        c = $urandom_range(0, 9);
        w[27:26] = (c < 4) ? 2'b00 : (c < 7) ? 2'b01 : (c < 9) ? 2'b10 : 2'b11;
        w[19:16] = 4'($urandom_range(0, 3));
        w[15:12] = 4'($urandom_range(0, 3));
        w[3:0]   = 4'($urandom_range(0, 3));
        return w;
    endfunction

    logic [31:0] snap_pc;

    initial begin
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        #1;
        chk("rst_valid", io.out_valid, 0);
        chk("rst_stalls", io.stall_count, 0);
        chk("rst_imm", io.out_imm, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;

        drive(1'b1, 32'hE2811F02, 32'h0, 1'b1, 1'b0); step();
        chk("add_valid", io.out_valid, 1);
        chk("add_imm", io.out_imm, 32'h8);
        chk("add_rd_rn", {io.out_rd, io.out_rn}, 8'h11);
        chk("add_imm_en", io.out_imm_en, 1);

        drive(1'b1, 32'hE1510002, 32'h4, 1'b1, 1'b0); step();
        chk("cmp_we", io.out_reg_we, 0);
        chk("cmp_rn_rm", {io.out_rn, io.out_rm, io.out_rm_used}, {4'd1, 4'd2, 1'b1});
        drive(1'b1, 32'hE3A03005, 32'h8, 1'b1, 1'b0); step();
        chk("mov_rn_used", io.out_rn_used, 0);
        chk("mov_imm", io.out_imm, 32'h5);

        drive(1'b1, 32'hE5904000, 32'hC, 1'b1, 1'b0); step();
        chk("ldr_load", io.out_mem_load, 1);
        drive(1'b1, 32'hE0845001, 32'h10, 1'b1, 1'b0); step();
        chk("bubble_valid", io.out_valid, 0);
        chk("bubble_stalls", io.stall_count, 1);
        step();
        chk("dep_rd", {io.out_valid, io.out_rd}, {1'b1, 4'd5});
        drive(1'b1, 32'hE5904000, 32'h14, 1'b1, 1'b0); step();
        drive(1'b1, 32'hE0865001, 32'h18, 1'b1, 1'b0); step();
        chk("indep_no_bubble", {io.out_valid, io.out_pc}, {1'b1, 32'h18});
        chk("indep_stalls", io.stall_count, 1);

        drive(1'b1, 32'hEAFFFFFE, 32'h100, 1'b1, 1'b0); step();
        chk("br_target", io.out_jump_target, 32'h100);
        chk("br_jump_we", {io.out_jump_en, io.out_reg_we}, 2'b10);
        drive(1'b1, 32'hEBFFFFFE, 32'h200, 1'b1, 1'b0); step();
`ifdef DECODE_BL_EN
        chk("bl_link", {io.out_reg_we, io.out_rd}, {1'b1, 4'd14});
`else
        chk("bl_link", {io.out_reg_we, io.out_rd}, {1'b0, 4'd0});
`endif

        drive(1'b1, 32'hE0821003, 32'h300, 1'b1, 1'b0); step();
        snap_pc = io.out_pc;
        drive(1'b1, 32'hE2833001, 32'h304, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_in_ready", io.in_ready, 0);
            chk("bp_stable", {io.out_valid, io.out_pc}, {1'b1, snap_pc});
        end
        drive(1'b1, 32'hE2833001, 32'h304, 1'b0, 1'b1); step();
        chk("flush_valid", io.out_valid, 0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); step();
        chk("flush_dropped", io.out_valid, 0);

        drive(1'b1, 32'hEC000000, 32'h400, 1'b1, 1'b0); step();
        chk("undef_flag", io.out_undef, 1);
        chk("undef_enables", {io.out_rn_used, io.out_rm_used, io.out_reg_we, io.out_imm_en,
                              io.out_mem_load, io.out_mem_store, io.out_jump_en}, 0);

        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_valid", io.out_valid, 0);
                chk("mid_rst_stalls", io.stall_count, 0);
                chk("mid_rst_fields", {io.out_imm, io.out_pc}, 0);
                chk("mid_rst_ctl", {io.out_rd, io.out_jump_target, io.out_cond, io.out_reg_we}, 0);
                m_vld = 0;
                m_stalls = 0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
            end
            drive(($urandom_range(0, 9) < 8), rand_instr(), $urandom & 32'hFFFF_FFFC,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
